// File: rtl/wasca_onchip_ram_arbiter.sv
// wasca_onchip_ram_arbiter
//
// This block lets two Avalon-MM masters share one single-port 4096x32 on-chip RAM.
// Master 0 is the CPU data master. Master 1 is the SCSP/bus-bridge DMA master.
//
// How it works:
//   - At most one RAM access is issued per cycle.
//   - Arbitration is round-robin. One master may win back-to-back for at most
//     HOLD_MAX grants while the other master is also requesting.
//   - Read data returns one cycle after the grant. It is tagged to the master
//     that issued the read.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   reset_req             RAM reset request; blocks all grants while high
//   m0_* / m1_*           Avalon-MM slave-side ports for master 0 / master 1
//                         (address, byteenable, read, write, writedata in;
//                          waitrequest, readdata, readdatavalid out)
//   mem_*                 RAM port (address, byteenable, chipselect, write,
//                          writedata, clken out; readdata in, 1-cycle latency)

`timescale 1ns / 1ps

module wasca_onchip_ram_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [3:0]  HoldLimit = 4'(HOLD_MAX);

    logic       req0, req1;
    logic [1:0] grant;      // one-hot: bit 0 = m0, bit 1 = m1
    logic       sel_read;   // granted access is a pure read

    // last_q is one-hot with the same encoding as grant.
    // Its reset value 2'b01 makes m0 win the first contention.
    logic [1:0] last_q, last_d;
    logic [3:0] hold_q, hold_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_tag_q, rd_tag_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grant decision
    always_comb begin
        grant = 2'b00;
        if (!(reset || reset_req)) begin
            if (req0 && req1) begin
                // last_q is always one-hot, so ~last_q selects the other master.
                grant = (hold_q < HoldLimit) ? last_q : ~last_q;
            end else begin
                grant = {req1, req0};
            end
        end
    end

    // RAM port mux
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        mem_chipselect = 1'b0;
        sel_read       = 1'b0;
        unique case (grant)
            2'b01: begin
                mem_address    = m0_address;
                mem_byteenable = m0_byteenable;
                mem_writedata  = m0_writedata;
                mem_write      = m0_write;
                mem_chipselect = 1'b1;
                // Read and write high together counts as a write.
                sel_read       = m0_read & ~m0_write;
            end
            2'b10: begin
                mem_address    = m1_address;
                mem_byteenable = m1_byteenable;
                mem_writedata  = m1_writedata;
                mem_write      = m1_write;
                mem_chipselect = 1'b1;
                sel_read       = m1_read & ~m1_write;
            end
            default: ;
        endcase
    end

    assign mem_clken = 1'b1;

    // Next-state logic
    always_comb begin
        last_d    = last_q;
        hold_d    = hold_q;
        rd_pend_d = sel_read;
        rd_tag_d  = rd_tag_q;
        if (grant != 2'b00) begin
            if (grant == last_q) begin
                hold_d = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
            end else begin
                last_d = grant;
                hold_d = 4'd1;
            end
            if (sel_read) begin
                rd_tag_d = grant[1];
            end
        end else begin
            hold_d = 4'd0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= 2'b01;
            hold_q    <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    // Master-side outputs
    assign m0_waitrequest = req0 & ~grant[0];
    assign m1_waitrequest = req1 & ~grant[1];

    // Read data goes to both masters. Each master uses readdatavalid to know
    // when the data is meant for it.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend_q & ~rd_tag_q;
    assign m1_readdatavalid = rd_pend_q &  rd_tag_q;

    // Keep the byteenable width tied to the data width.
    logic unused_be_w;
    assign unused_be_w = ^BE_W;

endmodule

// File: tb/tb_wasca_onchip_ram_arbiter.sv
// Testbench for wasca_onchip_ram_arbiter.
//
// The bench contains:
//   - a behavioural 1-cycle-latency RAM model,
//   - a shadow copy of that RAM for expected read data,
//   - a scoreboard of expected read returns (cycle, tag, data).

`timescale 1ns / 1ps

module tb_wasca_onchip_ram_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              reset_req;
    logic [ADDR_W-1:0] m0_address,   m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    wasca_onchip_ram_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .HOLD_MAX (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .reset_req        (reset_req),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] ram    [4096];
    logic [DATA_W-1:0] shadow [4096];

    typedef struct {
        int                cyc;
        logic              tag;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    // RAM model: registered read, byte-lane writes.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Read-return monitor: the expected return is the entry issued one cycle earlier.
    logic mon_ev, mon_et;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon_ev = (sb.size() > 0) && (sb[0].cyc == cyc - 1);
            mon_et = mon_ev ? sb[0].tag : 1'b0;
            chk("rdv0", {31'd0, m0_readdatavalid}, {31'd0, mon_ev & ~mon_et});
            chk("rdv1", {31'd0, m1_readdatavalid}, {31'd0, mon_ev & mon_et});
            if (mon_ev) begin
                if (mon_et) chk("rdata1", m1_readdata, sb[0].data);
                else        chk("rdata0", m0_readdata, sb[0].data);
                void'(sb.pop_front());
            end
        end
    end

    task automatic shadow_wr(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                             input logic [DATA_W-1:0] d);
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Check one cycle against the expected grant (g0/g1), then advance to posedge+1.
    task automatic step(input logic g0, input logic g1, input string name);
        logic              r0, r1;
        logic [ADDR_W-1:0] ea;
        logic [BE_W-1:0]   ebe;
        logic [DATA_W-1:0] ewd;
        logic              ew;
        @(negedge clk);
        r0  = m0_read | m0_write;
        r1  = m1_read | m1_write;
        ea  = g0 ? m0_address    : (g1 ? m1_address    : '0);
        ebe = g0 ? m0_byteenable : (g1 ? m1_byteenable : '0);
        ewd = g0 ? m0_writedata  : (g1 ? m1_writedata  : '0);
        ew  = g0 ? m0_write      : (g1 ? m1_write      : 1'b0);
        chk({name, ".wait0"}, {31'd0, m0_waitrequest}, {31'd0, r0 & ~g0});
        chk({name, ".wait1"}, {31'd0, m1_waitrequest}, {31'd0, r1 & ~g1});
        chk({name, ".cs"},    {31'd0, mem_chipselect}, {31'd0, g0 | g1});
        chk({name, ".wr"},    {31'd0, mem_write},      {31'd0, ew});
        chk({name, ".addr"},  {20'd0, mem_address},    {20'd0, ea});
        chk({name, ".be"},    {28'd0, mem_byteenable}, {28'd0, ebe});
        chk({name, ".wd"},    mem_writedata,           ewd);
        chk({name, ".clken"}, {31'd0, mem_clken},      32'd1);
        if (g0 && m0_read && !m0_write) sb.push_back('{cyc, 1'b0, shadow[m0_address]});
        if (g1 && m1_read && !m1_write) sb.push_back('{cyc, 1'b1, shadow[m1_address]});
        if (g0 && m0_write) shadow_wr(m0_address, m0_byteenable, m0_writedata);
        if (g1 && m1_write) shadow_wr(m1_address, m1_byteenable, m1_writedata);
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic set1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    initial begin
        logic [DATA_W-1:0] pat;
        for (int i = 0; i < 4096; i++) begin
            pat       = 32'hA5000000 ^ (i * 32'h00010101);
            ram[i]    = pat;
            shadow[i] = pat;
        end
        reset     = 1'b1;
        reset_req = 1'b0;
        set0(1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
        set1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        @(posedge clk);
        #1;

        // Under reset, m0's request just stalls.
        step(1'b0, 1'b0, "rst_a");
        step(1'b0, 1'b0, "rst_b");
        reset = 1'b0;

        // m0 reads alone: granted with zero wait, data returns next cycle.
        step(1'b1, 1'b0, "m0rd");
        set0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b0, 1'b0, "m0rd_ret");

        // m0 writes two bytes, then m1 reads the same word back.
        set0(1'b0, 1'b1, 12'h123, 4'h3, 32'hDEADBEEF);
        step(1'b1, 1'b0, "m0wr");
        set0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        set1(1'b1, 1'b0, 12'h123, 4'hF, 32'h0);
        step(1'b0, 1'b1, "m1rd");
        set1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b0, 1'b0, "m1rd_ret");

        // Both masters read continuously after reset: 4 grants to m0, then 4 to m1.
        reset = 1'b1;
        step(1'b0, 1'b0, "rst2");
        reset = 1'b0;
        set0(1'b1, 1'b0, 12'h200, 4'hF, 32'h0);
        set1(1'b1, 1'b0, 12'h300, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, "rr_m0a");
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, "rr_m1");
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0, "rr_m0b");
        set0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        set1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b0, 1'b0, "rr_idle");

        // m0 reads continuously. m1 asks once partway through and is served
        // once m0's hold runs out.
        set0(1'b1, 1'b0, 12'h040, 4'hF, 32'h0);
        step(1'b1, 1'b0, "hold_a");
        step(1'b1, 1'b0, "hold_b");
        set1(1'b1, 1'b0, 12'h055, 4'hF, 32'h0);
        step(1'b1, 1'b0, "hold_c");
        step(1'b1, 1'b0, "hold_d");
        step(1'b0, 1'b1, "hold_m1");
        set1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b1, 1'b0, "hold_e");
        set0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b0, 1'b0, "hold_idle");

        // m1 read, then reset_req for 3 cycles while both masters request.
        set1(1'b1, 1'b0, 12'h077, 4'hF, 32'h0);
        step(1'b0, 1'b1, "rq_m1");
        reset_req = 1'b1;
        set0(1'b1, 1'b0, 12'h011, 4'hF, 32'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, "rq_block");
        reset_req = 1'b0;
        step(1'b0, 1'b1, "rq_resume");
        set1(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b1, 1'b0, "rq_m0");
        set0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b0, 1'b0, "rq_idle");

        // Read and write high together: counted as a write, so no readdatavalid.
        set0(1'b1, 1'b1, 12'h2AA, 4'hF, 32'h12345678);
        step(1'b1, 1'b0, "rw");
        set0(1'b1, 1'b0, 12'h2AA, 4'hF, 32'h0);
        step(1'b1, 1'b0, "rw_rd");
        set0(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
        step(1'b0, 1'b0, "rw_ret");
        step(1'b0, 1'b0, "tail");

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
